// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer and the ControlUnit:
// sequencer state encoding and the ARF / IR control codes driven during a fetch.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DONE     = 2'd3
    } fetch_state_t;

    // ARF output-D select: memory address taken from PC
    localparam logic [1:0] ARF_OUTD_PC  = 2'b00;
    // ARF function: increment the selected registers
    localparam logic [1:0] ARF_FUN_INC  = 2'b01;
    // ARF register write enables: PC only, or nothing
    localparam logic [3:0] ARF_REG_PC   = 4'b1000;
    localparam logic [3:0] ARF_REG_NONE = 4'b0000;
    // IR function: load the selected half from memory
    localparam logic [1:0] IR_FUN_LOAD  = 2'b10;

    localparam int FETCH_COUNT_W = 16;

    function automatic logic in_fetch(input fetch_state_t s);
        return (s == FETCH_LO) || (s == FETCH_HI);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Two-beat instruction fetch: reads the low then high IR byte from memory at PC,
// incrementing PC each beat, then pulses Done and counts completed fetches.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Hold,
    input  logic                     Flush,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Mem_CS,
    output logic                     Mem_WR,
    output logic [1:0]               ARF_OutDSel,
    output logic [1:0]               ARF_FunSel,
    output logic [3:0]               ARF_RegSel,
    output logic                     IR_Enable,
    output logic                     IR_LH,
    output logic [1:0]               IR_Funsel,
    output logic [FETCH_COUNT_W-1:0] FetchCount
);

    fetch_state_t             state;
    fetch_state_t             state_next;
    logic [FETCH_COUNT_W-1:0] fetch_count;
    logic                     complete;
    logic                     active;

    // A fetch only counts when DONE is actually left, not while stalled or aborted.
    assign complete   = (state == DONE) && !Hold && !Flush;
    assign active     = in_fetch(state) && !Hold && !Flush;
    assign FetchCount = fetch_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            fetch_count <= '0;
        end else begin
            state <= state_next;
            if (complete)
                fetch_count <= fetch_count + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = IDLE;
        end else if (!Hold) begin
            unique case (state)
                IDLE:     state_next = Start ? FETCH_LO : IDLE;
                FETCH_LO: state_next = FETCH_HI;
                FETCH_HI: state_next = DONE;
                DONE:     state_next = Start ? FETCH_LO : IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Control codes are only presented on a beat that really writes PC and IR.
    always_comb begin
        Busy        = in_fetch(state);
        Done        = complete;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = ARF_REG_NONE;
        IR_Enable   = 1'b0;
        IR_LH       = 1'b0;
        IR_Funsel   = 2'b00;
        if (active) begin
            Mem_CS      = 1'b0;
            ARF_OutDSel = ARF_OUTD_PC;
            ARF_FunSel  = ARF_FUN_INC;
            ARF_RegSel  = ARF_REG_PC;
            IR_Enable   = 1'b1;
            IR_LH       = (state == FETCH_HI);
            IR_Funsel   = IR_FUN_LOAD;
        end
    end

endmodule
